// File: rtl/keypad_controller_if.sv
// Keypad controller bus: raw key inputs toward the controller, command and status outputs back.
interface keypad_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] keypad;
    logic       pin_error;
    logic       locked;
    logic [2:0] digit_count;

    modport master (
        output key_valid, key_code,
        input  keypad, pin_error, locked, digit_count
    );

    modport slave (
        input  key_valid, key_code,
        output keypad, pin_error, locked, digit_count
    );
endinterface

// File: rtl/keypad_controller.sv
// PIN-entry keypad front end: debounces raw keys, buffers a 4-digit BCD PIN and
// issues arm/disarm commands, with inactivity timeout and lockout after repeated failures.
module keypad_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] ARM_PIN         = 16'h1234,
    parameter int unsigned CMD_HOLD        = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned MAX_FAILS       = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 2000
) (
    input  logic                clk,
    input  logic                rst,
    keypad_controller_if.slave  kp_if
);

    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_ISSUE, S_LOCKOUT} state_t;

    logic [3:0]  r_db_code;
    logic [31:0] r_db_cnt;
    logic [31:0] r_rel_cnt;
    logic        r_wait_rel;
    logic        r_strobe;
    logic [3:0]  r_key;

    logic        w_same;
    logic [31:0] w_db_nxt;

    assign w_same   = (r_db_cnt != '0) && (kp_if.key_code == r_db_code);
    assign w_db_nxt = w_same ? (r_db_cnt + 32'd1) : 32'd1;

    // Accepted key is registered, so the FSM sees it one edge after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_code  <= '0;
            r_db_cnt   <= '0;
            r_rel_cnt  <= '0;
            r_wait_rel <= 1'b0;
            r_strobe   <= 1'b0;
            r_key      <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (r_wait_rel) begin
                r_db_cnt <= '0;
                if (kp_if.key_valid) begin
                    r_rel_cnt <= '0;
                end else if (r_rel_cnt + 32'd1 >= DEBOUNCE_CYCLES) begin
                    r_rel_cnt  <= '0;
                    r_wait_rel <= 1'b0;
                end else begin
                    r_rel_cnt <= r_rel_cnt + 32'd1;
                end
            end else if (kp_if.key_valid) begin
                r_db_code <= kp_if.key_code;
                if (w_db_nxt >= DEBOUNCE_CYCLES) begin
                    r_strobe   <= 1'b1;
                    r_key      <= kp_if.key_code;
                    r_wait_rel <= 1'b1;
                    r_db_cnt   <= '0;
                    r_rel_cnt  <= '0;
                end else begin
                    r_db_cnt <= w_db_nxt;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    state_t      r_state, w_state;
    logic [15:0] r_buf, w_buf;
    logic [2:0]  r_count, w_count;
    logic [31:0] r_fails, w_fails;
    logic [31:0] r_timer, w_timer;
    logic        r_arm, w_arm;
    logic        w_pin_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_count <= '0;
            r_fails <= '0;
            r_timer <= '0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_buf   <= w_buf;
            r_count <= w_count;
            r_fails <= w_fails;
            r_timer <= w_timer;
            r_arm   <= w_arm;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_buf       = r_buf;
        w_count     = r_count;
        w_fails     = r_fails;
        w_timer     = r_timer;
        w_arm       = r_arm;
        w_pin_error = 1'b0;
        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (r_strobe) begin
                    w_timer = '0;
                    if (r_key <= 4'd9) begin
                        if (r_count < 3'd4) begin
                            w_buf   = {r_buf[11:0], r_key};
                            w_count = r_count + 3'd1;
                            w_state = S_ENTRY;
                        end
                    end else if (r_key == 4'hA || r_key == 4'hB) begin
                        w_arm   = (r_key == 4'hA);
                        w_state = S_CHECK;
                    end else if (r_key == 4'hC) begin
                        w_buf   = '0;
                        w_count = '0;
                        w_state = S_IDLE;
                    end
                end else if (r_state == S_ENTRY) begin
                    if (r_timer >= TIMEOUT_CYCLES - 1) begin
                        w_buf   = '0;
                        w_count = '0;
                        w_timer = '0;
                        w_state = S_IDLE;
                    end else begin
                        w_timer = r_timer + 32'd1;
                    end
                end
            end
            S_CHECK: begin
                w_buf   = '0;
                w_count = '0;
                w_timer = '0;
                if (r_count == 3'd4 && r_buf == ARM_PIN) begin
                    w_fails = '0;
                    w_state = S_ISSUE;
                end else begin
                    w_pin_error = 1'b1;
                    w_fails     = r_fails + 32'd1;
                    w_state     = (r_fails + 32'd1 >= MAX_FAILS) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_timer >= CMD_HOLD - 1) begin
                    w_timer = '0;
                    w_state = S_IDLE;
                end else begin
                    w_timer = r_timer + 32'd1;
                end
            end
            S_LOCKOUT: begin
                if (r_timer >= LOCKOUT_CYCLES - 1) begin
                    w_timer = '0;
                    w_fails = '0;
                    w_state = S_IDLE;
                end else begin
                    w_timer = r_timer + 32'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign kp_if.keypad      = (r_state == S_ISSUE) ? (r_arm ? 4'b0011 : 4'b1100) : 4'b0000;
    assign kp_if.pin_error   = w_pin_error;
    assign kp_if.locked      = (r_state == S_LOCKOUT);
    assign kp_if.digit_count = r_count;

endmodule

// File: tb/tb_keypad_controller.sv
// Scoreboard bench for keypad_controller: stimulus pushes expected output events,
// a negedge monitor turns keypad/pin_error/locked activity into events and compares.
module tb_keypad_controller;

    localparam int EV_NONE = 0;
    localparam int EV_KP   = 1;
    localparam int EV_PE   = 2;
    localparam int EV_LK   = 3;

    typedef struct {
        int         kind;
        logic [3:0] val;
        int         start;
        int         len;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_p = 0;
    ev_t  q[$];

    keypad_controller_if kif ();

    keypad_controller #(
        .DEBOUNCE_CYCLES(4),
        .ARM_PIN        (16'h1234),
        .CMD_HOLD       (3),
        .TIMEOUT_CYCLES (1000),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (2000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .kp_if(kif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void sb_check(input ev_t got);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d val=%h start=%0d len=%0d",
                     got.kind, got.val, got.start, got.len);
        end else begin
            e = q.pop_front();
            if (e.kind != got.kind || e.val != got.val || e.start != got.start || e.len != got.len) begin
                errors++;
                $display("FAIL scoreboard got kind=%0d val=%h start=%0d len=%0d exp kind=%0d val=%h start=%0d len=%0d",
                         got.kind, got.val, got.start, got.len, e.kind, e.val, e.start, e.len);
            end
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    logic [3:0] kp_prev = 4'h0;
    logic [3:0] kp_val  = 4'h0;
    int         kp_start, kp_len;
    logic       lk_prev = 1'b0;
    int         lk_start, lk_len;

    always @(negedge clk) begin
        ev_t ev;
        if (kif.pin_error === 1'b1) begin
            ev.kind = EV_PE; ev.val = 4'h0; ev.start = cyc; ev.len = 1;
            sb_check(ev);
        end
        if (kif.keypad != 4'h0) begin
            if (kp_prev == 4'h0) begin
                kp_start = cyc; kp_len = 1; kp_val = kif.keypad;
            end else begin
                kp_len++;
                if (kif.keypad != kp_val) kp_val = 4'hF;
            end
        end else if (kp_prev != 4'h0) begin
            ev.kind = EV_KP; ev.val = kp_val; ev.start = kp_start; ev.len = kp_len;
            sb_check(ev);
        end
        kp_prev = kif.keypad;
        if (kif.locked) begin
            if (!lk_prev) begin
                lk_start = cyc; lk_len = 1;
            end else begin
                lk_len++;
            end
        end else if (lk_prev) begin
            ev.kind = EV_LK; ev.val = 4'h1; ev.start = lk_start; ev.len = lk_len;
            sb_check(ev);
        end
        lk_prev = kif.locked;
    end

    // Key held 6 sampled cycles, released 6; expectations are relative to the first sampled edge.
    task automatic key(input logic [3:0] c, input int kind, input logic [3:0] val, input int len);
        ev_t e;
        @(negedge clk);
        last_p = cyc + 1;
        if (kind == EV_KP) begin
            e.kind = EV_KP; e.val = val; e.start = last_p + 5; e.len = len;
            q.push_back(e);
        end else if (kind == EV_PE || kind == EV_LK) begin
            e.kind = EV_PE; e.val = 4'h0; e.start = last_p + 4; e.len = 1;
            q.push_back(e);
            if (kind == EV_LK) begin
                e.kind = EV_LK; e.val = 4'h1; e.start = last_p + 5; e.len = len;
                q.push_back(e);
            end
        end
        kif.key_code  = c;
        kif.key_valid = 1'b1;
        repeat (6) @(negedge clk);
        kif.key_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic dig(input logic [3:0] c);
        key(c, EV_NONE, 4'h0, 0);
    endtask

    task automatic pin(input logic [15:0] p);
        for (int unsigned i = 0; i < 4; i++) dig(p[15-4*i -: 4]);
    endtask

    initial begin
        ev_t e;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_keypad", int'(kif.keypad), 0);
        chk("rst_pin_error", int'(kif.pin_error), 0);
        chk("rst_locked", int'(kif.locked), 0);
        chk("rst_digit_count", int'(kif.digit_count), 0);
        rst = 1'b0;

        pin(16'h1234);
        chk("dc_after_1234", int'(kif.digit_count), 4);
        key(4'hA, EV_KP, 4'b0011, 3);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            kif.key_code  = 4'd5;
            kif.key_valid = (i % 2 == 0);
        end
        @(negedge clk);
        kif.key_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("dc_after_bounce", int'(kif.digit_count), 0);

        key(4'hA, EV_PE, 4'h0, 0);
        dig(4'h1);
        dig(4'hE);
        chk("dc_ignore_E", int'(kif.digit_count), 1);
        dig(4'hC);
        chk("dc_after_clear", int'(kif.digit_count), 0);
        pin(16'h1234);
        key(4'hB, EV_KP, 4'b1100, 3);

        for (int n = 0; n < 3; n++) begin
            pin(16'h1235);
            key(4'hB, (n == 2) ? EV_LK : EV_PE, 4'h0, 2000);
        end
        chk("locked_in_lockout", int'(kif.locked), 1);
        pin(16'h1234);
        dig(4'hA);
        chk("dc_in_lockout", int'(kif.digit_count), 0);
        chk("kp_in_lockout", int'(kif.keypad), 0);
        for (int i = 0; i < 3000 && kif.locked; i++) @(negedge clk);
        chk("lockout_exit", int'(kif.locked), 0);
        @(negedge clk);

        dig(4'h1);
        dig(4'h2);
        chk("dc_before_idle", int'(kif.digit_count), 2);
        while (cyc < last_p + 1003) @(negedge clk);
        chk("dc_last_cycle_before_timeout", int'(kif.digit_count), 2);
        @(negedge clk);
        chk("dc_after_timeout", int'(kif.digit_count), 0);
        pin(16'h1234);
        key(4'hB, EV_KP, 4'b1100, 3);

        pin(16'h1234);
        dig(4'h5);
        chk("dc_fifth_digit_ignored", int'(kif.digit_count), 4);
        key(4'hA, EV_KP, 4'b0011, 3);
        dig(4'h1);
        dig(4'h2);
        dig(4'hC);
        chk("dc_clear_mid_entry", int'(kif.digit_count), 0);
        pin(16'h1234);
        key(4'hA, EV_KP, 4'b0011, 3);

        pin(16'h1234);
        @(negedge clk);
        last_p = cyc + 1;
        e.kind = EV_KP; e.val = 4'b0011; e.start = last_p + 5; e.len = 1;
        q.push_back(e);
        kif.key_code  = 4'hA;
        kif.key_valid = 1'b1;
        repeat (6) @(negedge clk);
        chk("kp_issue_before_rst", int'(kif.keypad), 3);
        kif.key_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_keypad", int'(kif.keypad), 0);
        chk("arst_locked", int'(kif.locked), 0);
        chk("arst_pin_error", int'(kif.pin_error), 0);
        chk("arst_digit_count", int'(kif.digit_count), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pin(16'h1234);
        key(4'hA, EV_KP, 4'b0011, 3);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_controller.md
KEYPAD_CONTROLLER -- requirements
Module: keypad_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be updated on the rising edge of clk.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of stable cycles needed to accept a press or a release.
REQ-003 Parameter ARM_PIN, default 16'h1234, SHALL hold the 4-digit BCD PIN; the first-entered digit is in the most significant nibble.
REQ-004 Parameter CMD_HOLD, default 3, SHALL set the number of cycles an issued command is held on keypad.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the entry inactivity timeout.
REQ-006 Parameter MAX_FAILS, default 3, SHALL set the number of consecutive failed attempts that triggers lockout.
REQ-007 Parameter LOCKOUT_CYCLES, default 2000, SHALL set the lockout duration.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 key_valid  in  1  raw key-down level (may bounce).
REQ-011 key_code  in  4  raw key: 0-9 digit, 0xA ARM, 0xB DISARM, 0xC CLEAR, 0xD-0xF ignored.
REQ-012 keypad  out  4  command to the security FSM: 4'b0011 arm, 4'b1100 disarm, 4'b0000 idle.
REQ-013 pin_error  out  1  one-cycle pulse on a rejected attempt.
REQ-014 locked  out  1  high while in lockout.
REQ-015 digit_count  out  3  number of digits currently buffered (0-4).

Function
REQ-016 Debounce: a press SHALL be accepted when key_valid=1 and key_code is unchanged for DEBOUNCE_CYCLES consecutive sampled cycles; a change of key_code restarts the count.
REQ-017 One press SHALL yield exactly one accepted key; no further key is accepted until key_valid=0 for DEBOUNCE_CYCLES consecutive cycles.
REQ-018 FSM states SHALL be IDLE, ENTRY, CHECK, ISSUE and LOCKOUT.
REQ-019 IDLE/ENTRY, accepted digit: if digit_count<4, the buffer SHALL shift left one nibble with the digit inserted in the low nibble, digit_count SHALL increment, and the state SHALL go to ENTRY; if digit_count=4, the digit SHALL be ignored.
REQ-020 Accepted CLEAR SHALL zero the buffer and digit_count, go to IDLE, and not assert pin_error.
REQ-021 Accepted ARM or DISARM in IDLE/ENTRY SHALL latch the requested command and enter CHECK on the next edge.
REQ-022 CHECK (1 cycle): if digit_count=4 and buffer=ARM_PIN, go to ISSUE and clear the fail count; otherwise pulse pin_error, increment the fail count, clear the buffer, and go to IDLE (LOCKOUT if the fail count reaches MAX_FAILS).
REQ-023 ISSUE: keypad SHALL carry the latched command for exactly CMD_HOLD cycles, then return to 4'b0000, with the buffer cleared and the state back at IDLE.
REQ-024 Latency: for a command key accepted at edge N, keypad SHALL change at edge N+2.
REQ-025 ENTRY: if no key is accepted for TIMEOUT_CYCLES consecutive cycles, the buffer SHALL clear and the state return to IDLE, with no pin_error and no fail increment.
REQ-026 LOCKOUT: locked=1 for LOCKOUT_CYCLES, all keys ignored, keypad=0; on exit the fail count SHALL clear and the state go to IDLE.
REQ-027 Codes 0xD-0xF SHALL be debounced but have no effect.
REQ-028 Key presses arriving during CHECK or ISSUE SHALL be discarded, but the release requirement of REQ-017 still applies.
REQ-029 Command key pressed with digit_count=0 SHALL be handled as a failed attempt.
REQ-030 keypad SHALL never take any value other than 0000, 0011 or 1100.

Reset
REQ-031 While rst=1: keypad=0, pin_error=0, locked=0, digit_count=0, state=IDLE; buffer, fail count and all counters cleared; the release-wait flag cleared.
REQ-032 Reset asserted mid-ISSUE or mid-LOCKOUT SHALL force keypad=0 and locked=0 immediately, without waiting for the clock.

Verification
REQ-033 Press 1,2,3,4,ARM, each held 6 cycles with 6-cycle releases -> keypad=0011 for exactly 3 cycles, starting 2 edges after ARM is accepted; pin_error stays 0.
REQ-034 key_valid toggling every cycle for 20 cycles on digit 5 -> no key accepted; digit_count stays 0.
REQ-035 Enter 1,2,3,5,DISARM three times -> three pin_error pulses, then locked=1 for 2000 cycles; a correct PIN entered during lockout yields keypad=0.
REQ-036 Enter 1,2, then idle 1000 cycles -> digit_count returns to 0 with no pin_error; a subsequent 1,2,3,4,DISARM yields keypad=1100 for 3 cycles.
REQ-037 Enter 1,2,3,4,5,ARM -> the 5th digit is ignored and keypad=0011; a separate run of 1,2,CLEAR,1,2,3,4,ARM also yields keypad=0011.
REQ-038 Assert rst on the 2nd cycle of ISSUE -> keypad=0 asynchronously, with all outputs at their reset values.
